// File: rtl/nibble_serial_sub16.sv
// Serial subtractor: one 4-bit lookahead-borrow slice per cycle, LSB slice first.
// Define APPROX_LSN_EN to replace slice 0 with a borrow-free XOR approximation.
module nibble_serial_sub16 #(
   parameter int NIB = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*NIB-1:0] a,
   input  logic [4*NIB-1:0] b,
   input  logic            bin,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*NIB-1:0] diff,
   output logic            bout
);

   localparam int W  = 4 * NIB;
   localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_sh, b_sh, acc, acc_n;
   logic          bor;
   logic [CW-1:0] cnt;
   logic [3:0]    sd;
   logic          so;
   logic          last;

   // Borrow into every bit is a flat sum-of-products of g, p and the slice borrow-in.
   function automatic logic [4:0] sub4(input logic [3:0] x, input logic [3:0] y, input logic ci);
      logic [3:0] g, p, c;
      logic       co;
      g    = ~x & y;
      p    = ~(x ^ y);
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {co, x ^ y ^ c};
   endfunction

   assign last      = (cnt == LAST);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   always_comb begin
      {so, sd} = sub4(a_sh[3:0], b_sh[3:0], bor);
`ifdef APPROX_LSN_EN
      if (cnt == '0) begin
         sd = a_sh[3:0] ^ b_sh[3:0];
         so = b_sh[3] & ~a_sh[3];
      end
`endif
      // Result slices enter from the top so the word is aligned after NIB shifts.
      acc_n = (acc >> 4) | (W'(sd) << (W - 4));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
         bor  <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_sh <= a;
               b_sh <= b;
               bor  <= bin;
               cnt  <= '0;
            end
            BUSY: begin
               a_sh <= a_sh >> 4;
               b_sh <= b_sh >> 4;
               bor  <= so;
               acc  <= acc_n;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  diff <= acc_n;
                  bout <= so;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/nibble_serial_sub16.md
NIBBLE_SERIAL_SUB16 -- requirements
Module: nibble_serial_sub16

Interface
REQ-001 SHALL provide parameter NIB, default 4: number of 4-bit slices, legal range 1..8; operand width W = 4*NIB.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port in_valid, input, 1, operands present.
REQ-005 SHALL provide port in_ready, output, 1, block can accept operands.
REQ-006 SHALL provide port a, input, W, minuend.
REQ-007 SHALL provide port b, input, W, subtrahend.
REQ-008 SHALL provide port bin, input, 1, borrow-in.
REQ-009 SHALL provide port out_valid, output, 1, result available.
REQ-010 SHALL provide port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL provide port diff, output, W, registered difference.
REQ-012 SHALL provide port bout, output, 1, registered borrow-out.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, capture a, b and bin into internal registers, clear the slice counter, and move to BUSY.
REQ-016 SHALL, in BUSY, process one 4-bit slice per cycle, starting with slice 0 (LSBs) and ending with slice NIB-1.
REQ-017 SHALL compute each slice with lookahead borrow logic, not a ripple chain:
  - generate g = ~a & b; propagate p = ~(a ^ b);
  - the borrow into each bit is a two-level sum-of-products of g, p and the slice borrow-in;
  - difference bit = a ^ b ^ borrow.
REQ-018 SHALL register each slice borrow-out as the borrow-in for the next slice; slice 0 uses the captured bin.
REQ-019 SHALL, after slice NIB-1, load diff = (a - b - bin) mod 2^W and bout = 1 iff a < b + bin, then enter DONE.
REQ-020 SHALL raise out_valid exactly NIB cycles after the accept edge.
REQ-021 SHALL hold diff and bout stable in DONE until out_valid&&out_ready; on that edge it SHALL return to IDLE.
REQ-022 SHALL assert in_ready in the cycle after the output handshake; no overlap of output and input handshakes.
REQ-023 SHALL ignore in_valid while in BUSY or DONE; operand changes on a and b in those states SHALL not affect the result.
REQ-024 SHALL let diff and bout keep the last result in IDLE.

Reset
REQ-025 SHALL, on rst_n=0, immediately force state IDLE, counter=0, out_valid=0, diff=0 and bout=0, regardless of the clock.
REQ-026 SHALL discard any operation in BUSY or DONE when reset occurs mid-operation; no partial result is emitted.
REQ-027 SHALL drive in_ready=1 while in IDLE from reset onward.

Configuration
REQ-028 SHALL honour the macro APPROX_LSN_EN.
REQ-029 SHALL, when APPROX_LSN_EN is defined, compute slice 0 approximately:
  - diff[3:0] = a[3:0] ^ b[3:0], with bin ignored;
  - borrow into slice 1 = b[3] & ~a[3];
  - upper slices stay exact; bout is then relative to the approximate chain.
REQ-030 SHALL, when APPROX_LSN_EN is undefined, compute every slice exactly per REQ-017 to REQ-019.
REQ-031 SHALL keep latency and handshake timing identical in both configurations.

Verification (NIB=4)
REQ-032 SHALL pass a basic case: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, out_valid exactly 4 cycles after accept.
REQ-033 SHALL pass a full borrow chain: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1.
REQ-034 SHALL pass a borrow-in case: a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0.
REQ-035 SHALL pass a backpressure case: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> diff/bout unchanged, in_ready=0, no new accept; on release, one handshake, then in_ready=1 the next cycle.
REQ-036 SHALL pass a mid-operation reset: assert rst_n=0 after 2 BUSY cycles -> out_valid=0, diff=0, bout=0 immediately, in_ready=1; then a=0x0010, b=0x0001, bin=0 -> diff=0x000F, bout=0.
REQ-037 SHALL pass the approximate case: a=0x0013, b=0x0005, bin=1 -> with APPROX_LSN_EN diff=0x0016, bout=0; without it diff=0x000D, bout=0.
